// File: rtl/butterfly_pipe_if.sv
// Handshake/data bundle for butterfly_pipe.
//   master: producer/consumer side (drives operands, out_ready, ovf_clr)
//   slave : the butterfly itself (drives in_ready, results, ovf)
// Packed complex layout: {re[upper half], im[lower half]}, two's complement.
interface butterfly_pipe_if #(
    parameter int WIDTH    = 32,
    parameter int TW_WIDTH = 32
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    A;
    logic [WIDTH-1:0]    B;
    logic [TW_WIDTH-1:0] W;
    logic                inv;
    logic                scale;
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out0;
    logic [WIDTH-1:0]    out1;
    logic                ovf;
    logic                ovf_clr;

    modport master (
        output in_valid, A, B, W, inv, scale, out_ready, ovf_clr,
        input  in_ready, out_valid, out0, out1, ovf
    );

    modport slave (
        input  in_valid, A, B, W, inv, scale, out_ready, ovf_clr,
        output in_ready, out_valid, out0, out1, ovf
    );
endinterface

// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly: out0 = A + W*B, out1 = A - W*B.
// Twiddle components are Q1.(T-1); the complex product is rounded half-up back to
// sample precision and saturated, then sums/diffs are optionally halved and saturated.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high; flushes every stage, clears outputs and ovf
//   bus    butterfly_pipe_if.slave: in_valid/in_ready, A, B, W, inv, scale,
//          out_valid/out_ready, out0, out1, sticky ovf, ovf_clr
// Flow control is a global stall: every stage advances only when the output
// register is empty or being drained, so in_ready is the same advance signal.
module butterfly_pipe #(
    parameter int WIDTH    = 32,
    parameter int TW_WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    butterfly_pipe_if.slave   bus
);
    localparam int H = WIDTH / 2;
    localparam int T = TW_WIDTH / 2;
    localparam int P = H + T + 1;   // full product width, cannot overflow
    localparam int S = H + 2;       // sum width with headroom for the +1 of scaling

    localparam logic signed [P-1:0] HI_P   = P'({(H-1){1'b1}});
    localparam logic signed [P-1:0] LO_P   = ~HI_P;
    localparam logic signed [P-1:0] RND    = {{(P-T+1){1'b0}}, 1'b1, {(T-2){1'b0}}};
    localparam logic signed [T-1:0] TW_MIN = {1'b1, {(T-1){1'b0}}};
    localparam logic signed [T-1:0] TW_MAX = ~TW_MIN;

    // Returns {clipped, value} after clamping to the H-bit signed range.
    function automatic logic [H:0] sat_h(input logic signed [P-1:0] v);
        if (v > HI_P)      return {1'b1, HI_P[H-1:0]};
        else if (v < LO_P) return {1'b1, LO_P[H-1:0]};
        else               return {1'b0, v[H-1:0]};
    endfunction

    logic                adv;
    logic [3:1]          vld_d, vld_q;

    // S1: operands and mode
    logic signed [H-1:0] a_re1_d, a_im1_d, b_re1_d, b_im1_d;
    logic signed [H-1:0] a_re1_q, a_im1_q, b_re1_q, b_im1_q;
    logic signed [T-1:0] w_re1_d, w_im1_d, w_re1_q, w_im1_q;
    logic                scale1_d, scale1_q;

    // S2: rounded/saturated complex product plus pass-through of A
    logic signed [P-1:0] pr, pi, pr_rnd, pi_rnd;
    logic [H:0]          bwr_sat, bwi_sat;
    logic signed [H-1:0] bw_re2_d, bw_im2_d, a_re2_d, a_im2_d;
    logic signed [H-1:0] bw_re2_q, bw_im2_q, a_re2_q, a_im2_q;
    logic                bw_ovf2_d, bw_ovf2_q, scale2_d, scale2_q;

    // S3: results
    logic signed [S-1:0] s0r, s0i, s1r, s1i;
    logic [H:0]          o0r, o0i, o1r, o1i;
    logic [WIDTH-1:0]    out0_d, out1_d, out0_q, out1_q;
    logic                ovf_set, ovf_d, ovf_q;

    always_comb begin
        adv = !vld_q[3] || bus.out_ready;

        a_re1_d  = bus.A[WIDTH-1:H];
        a_im1_d  = bus.A[H-1:0];
        b_re1_d  = bus.B[WIDTH-1:H];
        b_im1_d  = bus.B[H-1:0];
        w_re1_d  = bus.W[TW_WIDTH-1:T];
        w_im1_d  = bus.W[T-1:0];
        scale1_d = bus.scale;
        // Conjugate: -(-1.0) is not representable, clamp silently (no ovf).
        if (bus.inv)
            w_im1_d = (bus.W[T-1:0] == TW_MIN) ? TW_MAX : -$signed(bus.W[T-1:0]);

        pr = P'(w_re1_q) * P'(b_re1_q) - P'(w_im1_q) * P'(b_im1_q);
        pi = P'(w_im1_q) * P'(b_re1_q) + P'(w_re1_q) * P'(b_im1_q);
        pr_rnd = (pr + RND) >>> (T - 1);
        pi_rnd = (pi + RND) >>> (T - 1);
        bwr_sat   = sat_h(pr_rnd);
        bwi_sat   = sat_h(pi_rnd);
        bw_re2_d  = bwr_sat[H-1:0];
        bw_im2_d  = bwi_sat[H-1:0];
        bw_ovf2_d = bwr_sat[H] | bwi_sat[H];
        a_re2_d   = a_re1_q;
        a_im2_d   = a_im1_q;
        scale2_d  = scale1_q;

        s0r = S'(a_re2_q) + S'(bw_re2_q);
        s0i = S'(a_im2_q) + S'(bw_im2_q);
        s1r = S'(a_re2_q) - S'(bw_re2_q);
        s1i = S'(a_im2_q) - S'(bw_im2_q);
        if (scale2_q) begin
            s0r = (s0r + S'(1)) >>> 1;
            s0i = (s0i + S'(1)) >>> 1;
            s1r = (s1r + S'(1)) >>> 1;
            s1i = (s1i + S'(1)) >>> 1;
        end
        o0r = sat_h(P'(s0r));
        o0i = sat_h(P'(s0i));
        o1r = sat_h(P'(s1r));
        o1i = sat_h(P'(s1i));
        out0_d = {o0r[H-1:0], o0i[H-1:0]};
        out1_d = {o1r[H-1:0], o1i[H-1:0]};

        // Flag only counts when a valid sample actually lands in S3.
        ovf_set = adv && vld_q[2] &&
                  (bw_ovf2_q | o0r[H] | o0i[H] | o1r[H] | o1i[H]);
        ovf_d = ovf_q;
        if (bus.ovf_clr) ovf_d = 1'b0;
        if (ovf_set)     ovf_d = 1'b1;

        vld_d = adv ? {vld_q[2:1], bus.in_valid} : vld_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            out0_q <= '0;
            out1_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q <= vld_d;
            ovf_q <= ovf_d;
            if (adv && vld_q[2]) begin
                out0_q <= out0_d;
                out1_q <= out1_d;
            end
        end
    end

    // Datapath registers need no reset; their valid bits gate them.
    always_ff @(posedge clk) begin
        if (adv) begin
            a_re1_q   <= a_re1_d;
            a_im1_q   <= a_im1_d;
            b_re1_q   <= b_re1_d;
            b_im1_q   <= b_im1_d;
            w_re1_q   <= w_re1_d;
            w_im1_q   <= w_im1_d;
            scale1_q  <= scale1_d;
            bw_re2_q  <= bw_re2_d;
            bw_im2_q  <= bw_im2_d;
            a_re2_q   <= a_re2_d;
            a_im2_q   <= a_im2_d;
            bw_ovf2_q <= bw_ovf2_d;
            scale2_q  <= scale2_d;
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld_q[3];
    assign bus.out0      = out0_q;
    assign bus.out1      = out1_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed bench for butterfly_pipe (WIDTH=32, TW_WIDTH=32): a vector table of
// single butterflies with hand-computed results, then stall, reset-flush and
// ovf set/clear race sequences.
module tb_butterfly_pipe;
    localparam int WIDTH    = 32;
    localparam int TW_WIDTH = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    butterfly_pipe_if #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) bif();
    butterfly_pipe #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    typedef struct {
        string       name;
        logic [31:0] a, b, w;
        logic        inv, scale;
        logic [31:0] e0, e1;
        logic        eovf;
    } vec_t;

    int tests = 0;
    int errs  = 0;
    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] cx(input int re, input int im);
        return {16'(re), 16'(im)};
    endfunction

    function automatic vec_t mk(input string n, input int ar, ai, br, bi, wr, wi,
                                input logic inv, input logic sc,
                                input int o0r, o0i, o1r, o1i, input logic ov);
        vec_t v;
        v.name = n; v.a = cx(ar, ai); v.b = cx(br, bi); v.w = cx(wr, wi);
        v.inv = inv; v.scale = sc; v.e0 = cx(o0r, o0i); v.e1 = cx(o1r, o1i);
        v.eovf = ov;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bif.A = v.a; bif.B = v.b; bif.W = v.w; bif.inv = v.inv; bif.scale = v.scale;
    endtask

    // Clears ovf, sends one sample, checks exact 3-cycle latency and results.
    task automatic run_vec(input vec_t v);
        @(negedge clk); bif.ovf_clr = 1'b1;
        @(negedge clk); bif.ovf_clr = 1'b0; drive(v); bif.in_valid = 1'b1;
        @(negedge clk); bif.in_valid = 1'b0;
        chk({v.name, " lat1"}, 32'(bif.out_valid), 32'd0);
        @(negedge clk);
        chk({v.name, " lat2"}, 32'(bif.out_valid), 32'd0);
        @(negedge clk);
        chk({v.name, " lat3"}, 32'(bif.out_valid), 32'd1);
        chk({v.name, " out0"}, bif.out0, v.e0);
        chk({v.name, " out1"}, bif.out1, v.e1);
        chk({v.name, " ovf"}, 32'(bif.ovf), 32'(v.eovf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent, rcvd;
        vec_t sat;

        vecs[0]  = mk("pass_re",     1000, 0, 2000, 0, 32767, 0, 0, 0, 3000, 0, -1000, 0, 0);
        vecs[1]  = mk("tw_negj",     1000, 0, 2000, 0, 0, -32768, 0, 0, 1000, -2000, 1000, 2000, 0);
        vecs[2]  = mk("tw_conj",     1000, 0, 2000, 0, 0, -32768, 1, 0, 1000, 2000, 1000, -2000, 0);
        vecs[3]  = mk("sat_pos",     32000, 0, 32000, 0, 32767, 0, 0, 0, 32767, 0, 1, 0, 1);
        vecs[4]  = mk("scale_sat",   32000, 0, 32000, 0, 32767, 0, 0, 1, 32000, 0, 1, 0, 0);
        vecs[5]  = mk("bw_clip",     0, 0, -32768, 0, -32768, 0, 0, 0, 32767, 0, -32767, 0, 1);
        vecs[6]  = mk("conj_min",    0, 0, 0, 100, 0, -32768, 1, 0, -100, 0, 100, 0, 0);
        vecs[7]  = mk("rnd_half_up", 0, 0, 1, 0, 16384, 0, 0, 0, 1, 0, -1, 0, 0);
        vecs[8]  = mk("rnd_half_neg",0, 0, -1, 0, 16384, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[9]  = mk("scale_rnd",   3, -3, 0, 0, 0, 0, 0, 1, 2, -1, 2, -1, 0);
        vecs[10] = mk("sat_neg",     -32768, 0, 32767, 0, 32767, 0, 0, 0, -2, 0, -32768, 0, 1);
        vecs[11] = mk("imag_path",   0, 500, 0, 1000, 32767, 0, 0, 0, 0, 1500, 0, -500, 0);
        vecs[12] = mk("tw_j_half",   0, 0, 2000, 0, 0, 16384, 0, 0, 0, 1000, 0, -1000, 0);
        sat = vecs[3];

        reset = 1'b1;
        bif.in_valid = 1'b0; bif.A = '0; bif.B = '0; bif.W = '0;
        bif.inv = 1'b0; bif.scale = 1'b0; bif.out_ready = 1'b1; bif.ovf_clr = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst out_valid", 32'(bif.out_valid), 32'd0);
        chk("rst out0", bif.out0, 32'd0);
        chk("rst out1", bif.out1, 32'd0);
        chk("rst ovf", 32'(bif.ovf), 32'd0);
        chk("rst in_ready", 32'(bif.in_ready), 32'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stream 8 samples with a 3-cycle downstream stall.
        sent = 0; rcvd = 0;
        bif.B = '0; bif.W = '0; bif.inv = 1'b0; bif.scale = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            bif.out_ready = !(cyc >= 6 && cyc < 9);
            #1;
            if (bif.out_valid && bif.out_ready) begin
                chk("stream order", bif.out0, cx(100 + rcvd, 0));
                rcvd++;
            end
            if (!bif.out_ready) chk("stall in_ready", 32'(bif.in_ready), 32'd0);
            bif.in_valid = (sent < 8);
            bif.A = cx(100 + sent, 0);
            if (bif.in_valid && bif.in_ready) sent++;
        end
        bif.in_valid = 1'b0; bif.out_ready = 1'b1;
        chk("stream sent", 32'(sent), 32'd8);
        chk("stream rcvd", 32'(rcvd), 32'd8);

        // Reset with two saturating samples in flight: nothing may emerge.
        @(negedge clk); drive(sat); bif.in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk); bif.in_valid = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        chk("flush in_ready", 32'(bif.in_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("flush out_valid", 32'(bif.out_valid), 32'd0);
            chk("flush ovf", 32'(bif.ovf), 32'd0);
            @(negedge clk);
        end
        run_vec(vecs[0]);

        // ovf_clr in the same cycle the saturating sample loads S3: set wins.
        @(negedge clk); bif.ovf_clr = 1'b1;
        @(negedge clk); bif.ovf_clr = 1'b0; drive(sat); bif.in_valid = 1'b1;
        @(negedge clk); bif.in_valid = 1'b0;
        chk("race pre ovf", 32'(bif.ovf), 32'd0);
        @(negedge clk); bif.ovf_clr = 1'b1;
        @(negedge clk); bif.ovf_clr = 1'b0;
        chk("race out_valid", 32'(bif.out_valid), 32'd1);
        chk("race ovf set wins", 32'(bif.ovf), 32'd1);
        @(negedge clk); bif.ovf_clr = 1'b1;
        @(negedge clk); bif.ovf_clr = 1'b0;
        chk("ovf cleared", 32'(bif.ovf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
